// File: rtl/pattern_hit_logger.sv
// Timestamps hits from the 1-0-9-4 sequence detector, counts them and queues the
// timestamps for a host. Optional macro PATTERN_LOG_GAP_EN adds the last_gap port.
module pattern_hit_logger #(
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     pattern,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  output logic [CNT_W-1:0]         hit_count,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow
`ifdef PATTERN_LOG_GAP_EN
  ,
  output logic [TS_W-1:0]          last_gap
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [AW-1:0]    PTR_ZERO  = AW'(0);
  localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
  localparam logic [FW-1:0]    FILL_TWO  = FW'(2);
  localparam logic [FW-1:0]    FILL_ZERO = FW'(0);
  localparam logic [FW-1:0]    FILL_FULL = FW'(DEPTH);
  localparam logic [TS_W-1:0]  TS_ONE    = TS_W'(1);
  localparam logic [TS_W-1:0]  TS_ZERO   = TS_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            full;
  logic            hit;
  logic            pop;
  logic            push;
  logic            drop;
  logic [FW-1:0]   fill_nxt;
  logic [TS_W-1:0] head_nxt;

  // Handshake decode, next occupancy and next head value.
  always_comb begin
    full     = (fill == FILL_FULL);
    hit      = pattern & ~clear;
    pop      = rd_valid & rd_ready & ~clear;
    push     = hit & (~full | pop);
    drop     = hit & full & ~pop;
    fill_nxt = fill;
    head_nxt = rd_data;

    case ({push, pop})
      2'b10:   fill_nxt = fill + FILL_ONE;
      2'b01:   fill_nxt = fill - FILL_ONE;
      default: fill_nxt = fill;
    endcase

    // The head after a pop is the next stored entry, or the incoming hit when
    // the FIFO held only the entry being popped.
    if (pop) begin
      if (fill >= FILL_TWO) begin
        head_nxt = mem[rd_ptr + PTR_ONE];
      end else if (push) begin
        head_nxt = ts;
      end else begin
        head_nxt = rd_data;
      end
    end else if (push && (fill == FILL_ZERO)) begin
      head_nxt = ts;
    end else begin
      head_nxt = rd_data;
    end
  end

  // Cycle counter, FIFO state, hit counter and overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts        <= TS_ZERO;
      wr_ptr    <= PTR_ZERO;
      rd_ptr    <= PTR_ZERO;
      fill      <= FILL_ZERO;
      rd_valid  <= 1'b0;
      rd_data   <= TS_ZERO;
      hit_count <= CNT_ZERO;
      overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TS_ZERO;
      end
    end else if (clear) begin
      ts        <= TS_ZERO;
      wr_ptr    <= PTR_ZERO;
      rd_ptr    <= PTR_ZERO;
      fill      <= FILL_ZERO;
      rd_valid  <= 1'b0;
      rd_data   <= TS_ZERO;
      hit_count <= CNT_ZERO;
      overflow  <= 1'b0;
    end else begin
      ts       <= ts + TS_ONE;
      fill     <= fill_nxt;
      rd_valid <= (fill_nxt != FILL_ZERO);
      rd_data  <= head_nxt;
      if (push) begin
        mem[wr_ptr] <= ts;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (hit && !(&hit_count)) begin
        hit_count <= hit_count + CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef PATTERN_LOG_GAP_EN
  logic [TS_W-1:0] prev_ts;
  logic            have_prev;

  // Interval between consecutive hits, dropped ones included.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_ts   <= TS_ZERO;
      have_prev <= 1'b0;
      last_gap  <= TS_ZERO;
    end else if (clear) begin
      prev_ts   <= TS_ZERO;
      have_prev <= 1'b0;
      last_gap  <= TS_ZERO;
    end else if (hit) begin
      prev_ts   <= ts;
      have_prev <= 1'b1;
      if (have_prev) begin
        last_gap <= ts - prev_ts;
      end
    end
  end
`endif

endmodule
